// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM state type and BCD constants
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [4:0] BCD_RADIX = 5'd10;
endpackage

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub: one-digit BCD subtract with borrow in/out
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);
  logic signed [4:0] w_t;
  logic [4:0] w_f;
  assign w_t = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({4'd0, bin});
  assign w_f = w_t + BCD_RADIX;
  assign bout = w_t[4];
  assign d = bout ? w_f[3:0] : w_t[3:0];
endmodule

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: digit-serial |a-b| with sign over packed BCD operands
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  negative,
  output logic                  invalid
);
  localparam int W = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  state_t r_state, w_next_state;
  logic [W-1:0] r_a, r_b, r_r;
  logic r_borrow;
  logic [IW-1:0] r_idx;
  logic w_last, w_bad, w_bout;
  logic [3:0] w_x, w_y, w_d;
  logic [W+3:0] w_cat;
  assign w_last = r_idx == IW'(DIGITS - 1);
  assign w_x = (r_state == FIX) ? 4'd0 : r_a[3:0];
  assign w_y = (r_state == FIX) ? r_r[3:0] : r_b[3:0];
  assign w_cat = {w_d, r_r};
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  bcd_digit_sub u_digit (
    .x(w_x),
    .y(w_y),
    .bin(r_borrow),
    .d(w_d),
    .bout(w_bout)
  );
  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      w_bad = w_bad | (r_a[4*i+:4] > BCD_MAX) | (r_b[4*i+:4] > BCD_MAX);
  end
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: w_next_state = start ? SUB : IDLE;
      SUB:  w_next_state = w_bad ? DONE : !w_last ? SUB : w_bout ? FIX : DONE;
      FIX:  w_next_state = w_last ? DONE : FIX;
      DONE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next_state;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_r <= '0;
      r_borrow <= 1'b0;
      r_idx <= '0;
      diff <= '0;
      negative <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a <= a;
          r_b <= b;
          r_r <= '0;
          r_borrow <= 1'b0;
          r_idx <= '0;
          diff <= '0;
          negative <= 1'b0;
          invalid <= 1'b0;
        end
        SUB: if (w_bad) begin
          invalid <= 1'b1;
        end else begin
          r_a <= r_a >> 4;
          r_b <= r_b >> 4;
          r_r <= w_cat[W+3:4];
          r_borrow <= w_last ? 1'b0 : w_bout;
          r_idx <= w_last ? '0 : r_idx + 1'b1;
          if (w_last && !w_bout) diff <= w_cat[W+3:4];
        end
        FIX: begin
          r_r <= w_cat[W+3:4];
          r_borrow <= w_last ? 1'b0 : w_bout;
          r_idx <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) begin
            diff <= w_cat[W+3:4];
            negative <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
